debounce_arbiter: RTL and testbench

- Debounces NB_BTN push-buttons using one shared stability counter driven by the tempo-tick strobe tp_i.
- A round-robin controller grants the counter to one channel at a time.
- It commits the new stable level only after MAX_COUNT consecutive tp_i strobes with no bounce.
- Sits between board button pins and the TapTempo core; rise_o feeds the tap-capture logic.

---
 rtl/debounce_arbiter.sv | 109 ++++++++++
 tb/tb_debounce_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_arbiter.sv
// Multi-channel push-button debouncer sharing one stability counter between channels.
// A round-robin arbiter lends the counter to one changed channel at a time.
module debounce_arbiter #(
    parameter int NB_BTN          = 4,
    parameter int PULSE_PER_NS    = 5120,
    parameter int DEBOUNCE_PER_NS = 20_971_520,
    localparam int MAX_COUNT      = DEBOUNCE_PER_NS / PULSE_PER_NS,
    localparam int CNT_W          = $clog2(MAX_COUNT + 1),
    localparam int IDX_W          = (NB_BTN > 1) ? $clog2(NB_BTN) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tp_i,
    input  logic [NB_BTN-1:0] btn_i,
    output logic [NB_BTN-1:0] btn_o,
    output logic [NB_BTN-1:0] rise_o,
    output logic              busy_o,
    output logic [IDX_W-1:0]  owner_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]        state;
    logic [NB_BTN-1:0] sync_meta;
    logic [NB_BTN-1:0] sync_s;
    logic [NB_BTN-1:0] req;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_valid;
    logic [CNT_W-1:0]  count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= btn_i;
            sync_s    <= sync_meta;
        end
    end

    // A channel wants the counter whenever its synchronised level differs from the committed one.
    assign req = sync_s ^ btn_o;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int j = NB_BTN - 1; j >= 0; j--) begin
            if (req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
        for (int j = NB_BTN - 1; j >= 0; j--) begin
            if (req[j] && (j > int'(last))) begin
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            owner_o <= '0;
            last    <= IDX_W'(NB_BTN - 1);
            count   <= '0;
            btn_o   <= '0;
            rise_o  <= '0;
        end else begin
            rise_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_o <= grant_idx;
                        last    <= grant_idx;
                        count   <= '0;
                        state   <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // A bounce back to the stable level aborts regardless of tp_i.
                    if (!req[owner_o]) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else if (tp_i && (count == CNT_W'(MAX_COUNT - 1))) begin
                        state <= ST_COMMIT;
                    end else if (tp_i) begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    btn_o[owner_o]  <= sync_s[owner_o];
                    rise_o[owner_o] <= sync_s[owner_o];
                    count           <= '0;
                    state           <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state == ST_COUNT) || (state == ST_COMMIT);

endmodule

// File: tb/tb_debounce_arbiter.sv
// Bench for debounce_arbiter: directed button patterns, expected grants and commits
// are queued by the stimulus and checked by an independent monitor.
module tb_debounce_arbiter;

    localparam int NB   = 4;
    localparam int MAXC = 4;
    localparam logic [31:0] ANY_CYC = 32'hFFFF_FFFF;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          tp_i  = 1'b0;
    logic [NB-1:0] btn_i = '0;
    logic [NB-1:0] btn_o;
    logic [NB-1:0] rise_o;
    logic          busy_o;
    logic [1:0]    owner_o;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    logic          chk_grant  = 1'b1;
    logic          done       = 1'b0;
    logic          final_done = 1'b0;
    logic          rst_seen   = 1'b0;
    logic          prev_busy  = 1'b0;
    logic [NB-1:0] prev_btn   = '0;
    logic [33:0]   ge;
    logic [39:0]   ce;

    // Entries carry the expected cycle (ANY_CYC = unchecked) plus owner or {btn_o, rise_o}.
    logic [33:0] grant_q[$];
    logic [39:0] commit_q[$];

    debounce_arbiter #(
        .NB_BTN(NB),
        .PULSE_PER_NS(1),
        .DEBOUNCE_PER_NS(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .tp_i(tp_i),
        .btn_i(btn_i),
        .btn_o(btn_o),
        .rise_o(rise_o),
        .busy_o(busy_o),
        .owner_o(owner_o)
    );

    // Clock / reset / tempo strobe: the DUT sees tp_i at posedges p with p % 3 == 1.
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) tp_i = ((cyc % 3) == 0);

    // Cycle at which btn_o updates for a clean single-channel edge driven just after posedge p0.
    function automatic int exp_commit(input int p0);
        int p;
        p = p0 + 4;
        while ((p % 3) != 1) p++;
        return p + 3 * (MAXC - 1) + 1;
    endfunction

    task automatic push_grant(input int c, input logic [1:0] o);
        grant_q.push_back({32'(c), o});
    endtask

    task automatic push_commit(input int c, input logic [NB-1:0] b, input logic [NB-1:0] r);
        commit_q.push_back({32'(c), b, r});
    endtask

    task automatic wait_phase(input int r);
        do @(negedge clk_i); while ((cyc % 3) != r);
    endtask

    task automatic do_reset(input logic [NB-1:0] val, output int k);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        btn_i = val;
        repeat (2) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        k = cyc;
    endtask

    // Monitor / scoreboard
    always begin
        @(negedge clk_i or posedge rst_i);
        if (rst_i) begin
            if (!rst_seen) begin
                #1;
                rst_seen = 1'b1;
                checks += 4;
                if (btn_o !== '0) begin
                    failures++;
                    $display("FAIL reset_btn got=%b exp=0000", btn_o);
                end
                if (rise_o !== '0) begin
                    failures++;
                    $display("FAIL reset_rise got=%b exp=0000", rise_o);
                end
                if (busy_o !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_busy got=%b exp=0", busy_o);
                end
                if (owner_o !== 2'd0) begin
                    failures++;
                    $display("FAIL reset_owner got=%0d exp=0", owner_o);
                end
            end
        end else begin
            rst_seen = 1'b0;
            if (busy_o && !prev_busy && chk_grant) begin
                checks++;
                if (grant_q.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected cyc=%0d got owner=%0d exp none", cyc, owner_o);
                end else begin
                    ge = grant_q.pop_front();
                    if (owner_o != ge[1:0] || (ge[33:2] != ANY_CYC && ge[33:2] != 32'(cyc))) begin
                        failures++;
                        $display("FAIL grant cyc=%0d owner=%0d exp cyc=%0d owner=%0d",
                                 cyc, owner_o, $signed(ge[33:2]), ge[1:0]);
                    end
                end
            end
            if (btn_o != prev_btn) begin
                checks++;
                if (commit_q.size() == 0) begin
                    failures++;
                    $display("FAIL commit_unexpected cyc=%0d got btn=%b rise=%b exp none", cyc, btn_o, rise_o);
                end else begin
                    ce = commit_q.pop_front();
                    if (btn_o != ce[7:4] || rise_o != ce[3:0] ||
                        (ce[39:8] != ANY_CYC && ce[39:8] != 32'(cyc))) begin
                        failures++;
                        $display("FAIL commit cyc=%0d btn=%b rise=%b exp cyc=%0d btn=%b rise=%b",
                                 cyc, btn_o, rise_o, $signed(ce[39:8]), ce[7:4], ce[3:0]);
                    end
                end
            end else if (rise_o != '0) begin
                checks++;
                failures++;
                $display("FAIL rise_spurious cyc=%0d got rise=%b exp=0000", cyc, rise_o);
            end
            if (done && !final_done) begin
                final_done = 1'b1;
                checks += 2;
                if (grant_q.size() != 0) begin
                    failures++;
                    $display("FAIL grant_pending got=%0d exp=0", grant_q.size());
                end
                if (commit_q.size() != 0) begin
                    failures++;
                    $display("FAIL commit_pending got=%0d exp=0", commit_q.size());
                end
            end
        end
        prev_busy = busy_o;
        prev_btn  = btn_o;
    end

    // Stimulus
    initial begin
        int k;
        int p0;
        int t;
        #1 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // Clean press on channel 1; grant coincides with a tp_i that must not count.
        wait_phase(1);
        p0 = cyc;
        btn_i[1] = 1'b1;
        push_grant(p0 + 3, 2'd1);
        push_commit(exp_commit(p0), 4'b0010, 4'b0010);
        repeat (30) @(negedge clk_i);

        // Bounce on channel 0: first attempt aborts, second commits.
        wait_phase(0);
        p0 = cyc;
        btn_i[0] = 1'b1;
        push_grant(p0 + 3, 2'd0);
        repeat (5) @(negedge clk_i);
        btn_i[0] = 1'b0;
        repeat (3) @(negedge clk_i);
        p0 = cyc;
        btn_i[0] = 1'b1;
        push_grant(p0 + 3, 2'd0);
        push_commit(exp_commit(p0), 4'b0011, 4'b0001);
        repeat (30) @(negedge clk_i);

        // Release of channel 0: level falls, no rise pulse.
        @(negedge clk_i);
        p0 = cyc;
        btn_i[0] = 1'b0;
        push_grant(p0 + 3, 2'd0);
        push_commit(exp_commit(p0), 4'b0010, 4'b0000);
        repeat (30) @(negedge clk_i);

        // Contention: all four pressed out of reset, served 0,1,2,3.
        do_reset(4'b1111, k);
        push_grant(k + 3, 2'd0);
        push_grant(-1, 2'd1);
        push_grant(-1, 2'd2);
        push_grant(-1, 2'd3);
        push_commit(exp_commit(k), 4'b0001, 4'b0001);
        push_commit(-1, 4'b0011, 4'b0010);
        push_commit(-1, 4'b0111, 4'b0100);
        push_commit(-1, 4'b1111, 4'b1000);
        repeat (90) @(negedge clk_i);

        // Fairness: channel 0 chatters, channel 2 held high must still commit.
        do_reset(4'b0000, k);
        @(negedge clk_i);
        btn_i[2] = 1'b1;
        btn_i[0] = 1'b1;
        push_grant(-1, 2'd0);
        push_grant(-1, 2'd2);
        push_commit(-1, 4'b0100, 4'b0100);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (btn_o[2]) break;
            if ((i % 2) == 1) btn_i[0] = ~btn_i[0];
        end
        chk_grant = 1'b0;
        btn_i[0] = 1'b0;
        repeat (20) @(negedge clk_i);
        chk_grant = 1'b1;

        // Reset mid-count on channel 3, after its 2nd counted tp_i.
        do_reset(4'b0000, k);
        wait_phase(0);
        p0 = cyc;
        btn_i[3] = 1'b1;
        push_grant(p0 + 3, 2'd3);
        t = p0 + 4;
        while ((t % 3) != 1) t++;
        t = t + 3;
        while (cyc < t) @(negedge clk_i);
        #2 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b0;
        k = cyc;
        push_grant(k + 3, 2'd3);
        push_commit(exp_commit(k), 4'b1000, 4'b1000);
        repeat (30) @(negedge clk_i);

        done = 1'b1;
        repeat (3) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
